// File: rtl/insn_loader.sv
// ============================================================================
// Module   : insn_loader
// Brief    : Loads a length-prefixed, checksummed byte stream into instruction
//            memory, releases the decoder from reset, and serves its fetches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module insn_loader #(
  parameter int          AW       = 13,
  parameter logic [31:0] EOC_WORD = {5'd31, 27'd0}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic [7:0]    h_data,
  input  logic [AW-1:0] iaddr,
  output logic [31:0]   idata,
  output logic          core_rst_n,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_cnt
);

  localparam logic [16:0] c_DEPTH = 17'd1 << AW;

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_len;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_xor;
  logic [23:0] r_sr;
  logic [AW:0] r_word_cnt;
  logic        r_core_rst_n;
  logic [31:0] r_mem [0:(1<<AW)-1];

  logic        w_accept;
  logic        w_mem_we;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_last_word;
  logic        w_fetch_hit;

  assign h_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  assign w_accept = h_valid && h_ready;

  assign w_len       = {r_len[15:8], h_data};
  assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > c_DEPTH);
  // N is at most 2^AW, so the 17-bit compare covers the full-depth case.
  assign w_last_word = ((17'(r_word_cnt) + 17'd1) == {1'b0, r_len});
  assign w_mem_we    = w_accept && (r_state == S_PAYLOAD) && (r_bcnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LEN_HI;
      r_len        <= 16'd0;
      r_bcnt       <= 2'd0;
      r_xor        <= 8'd0;
      r_sr         <= 24'd0;
      r_word_cnt   <= '0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_core_rst_n <= (r_state == S_DONE);
      if (w_accept) begin
        case (r_state)
          S_LEN_HI: begin
            r_len[15:8] <= h_data;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len[7:0] <= h_data;
            r_state    <= w_len_bad ? S_ERR : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            r_xor  <= r_xor ^ h_data;
            r_bcnt <= r_bcnt + 2'd1;
            r_sr   <= {r_sr[15:0], h_data};
            if (r_bcnt == 2'd3) begin
              r_word_cnt <= r_word_cnt + 1'b1;
              if (w_last_word) r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            r_state <= (h_data == r_xor) ? S_DONE : S_ERR;
          end
          default: ;
        endcase
      end
    end
  end

  // Memory deliberately has no reset; stale words are hidden by the word_cnt compare.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_word_cnt[AW-1:0]] <= {r_sr, h_data};
  end

  assign w_fetch_hit = (r_state == S_DONE) && ({1'b0, iaddr} < r_word_cnt);
  assign idata       = w_fetch_hit ? r_mem[iaddr] : EOC_WORD;

  assign core_rst_n = r_core_rst_n;
  assign load_done  = (r_state == S_DONE);
  assign load_err   = (r_state == S_ERR);
  assign word_cnt   = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_insn_loader.sv
// ============================================================================
// Module   : tb_insn_loader
// Brief    : Randomized self-checking bench for insn_loader against a
//            stream-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_insn_loader;

  localparam int          AW  = 13;
  localparam logic [31:0] EOC = {5'd31, 27'd0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_valid = 1'b0;
  logic          h_ready;
  logic [7:0]    h_data = 8'd0;
  logic [AW-1:0] iaddr = '0;
  logic [31:0]   idata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_cnt;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] exp_w [0:(1<<AW)-1];

  insn_loader #(.AW(AW), .EOC_WORD(EOC)) dut (
    .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_ready(h_ready),
    .h_data(h_data), .iaddr(iaddr), .idata(idata), .core_rst_n(core_rst_n),
    .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 3ms)", $time);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    h_valid = 1'b1;
    h_data  = b;
    ncmp++;
    if (h_ready !== 1'b1) begin
      nerr++;
      $display("FAIL send_ready: h_ready=%b required 1 (byte %02h)", h_ready, b);
    end
    @(posedge clk);
    #1 h_valid = 1'b0;
  endtask

  // Reference: checksum = byte-fold of XOR of all payload words.
  task automatic load_prog(input int n, input bit preset, input bit gaps,
                           input bit bad_csum, input bit chk_mask);
    logic [31:0] x;
    logic [7:0]  cs;
    logic [7:0]  q[$];
    x = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (!preset) exp_w[i] = $urandom;
      x ^= exp_w[i];
    end
    cs = x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
    if (bad_csum) cs = cs ^ (8'd1 << $urandom_range(0, 7));
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      q.push_back(exp_w[i][31:24]); q.push_back(exp_w[i][23:16]);
      q.push_back(exp_w[i][15:8]);  q.push_back(exp_w[i][7:0]);
    end
    q.push_back(cs);
    foreach (q[k]) begin
      if (chk_mask) begin
        iaddr = AW'($urandom_range(0, 5));
        #1;
        ncmp++;
        if (idata !== EOC || core_rst_n !== 1'b0) begin
          nerr++;
          $display("FAIL fetch_masked: iaddr=%0d idata=%08h core_rst_n=%b required %08h/0",
                   iaddr, idata, core_rst_n, EOC);
        end
      end
      send_byte(q[k], gaps);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    ncmp++;
    if (h_ready !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
        core_rst_n !== 1'b0 || word_cnt !== '0 || idata !== EOC) begin
      nerr++;
      $display("FAIL reset: rdy=%b done=%b err=%b crst=%b wc=%0d idata=%08h required 1/0/0/0/0/%08h",
               h_ready, load_done, load_err, core_rst_n, word_cnt, idata, EOC);
    end
  endtask

  task automatic test_basic();
    do_reset();
    exp_w[0] = 32'h1234_5678;
    load_prog(1, 1'b1, 1'b0, 1'b0, 1'b0);
    ncmp++;
    if (load_done !== 1'b1 || core_rst_n !== 1'b0) begin
      nerr++;
      $display("FAIL basic_latency: done=%b crst=%b required 1/0", load_done, core_rst_n);
    end
    @(posedge clk); #1;
    ncmp++;
    if (core_rst_n !== 1'b1) begin
      nerr++;
      $display("FAIL basic_core_rst: core_rst_n=%b required 1", core_rst_n);
    end
    iaddr = '0; #1;
    ncmp++;
    if (idata !== 32'h1234_5678) begin
      nerr++;
      $display("FAIL basic_word0: idata=%08h required 12345678", idata);
    end
    iaddr = AW'(1); #1;
    ncmp++;
    if (idata !== EOC) begin
      nerr++;
      $display("FAIL basic_word1: idata=%08h required %08h", idata, EOC);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    load_prog(3, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    ncmp++;
    if (word_cnt !== (AW+1)'(3) || h_ready !== 1'b0 || load_done !== 1'b1) begin
      nerr++;
      $display("FAIL gaps_status: wc=%0d rdy=%b done=%b required 3/0/1", word_cnt, h_ready, load_done);
    end
    for (int i = 0; i < 4; i++) begin
      iaddr = AW'(i); #1;
      ncmp++;
      if (idata !== ((i < 3) ? exp_w[i] : EOC)) begin
        nerr++;
        $display("FAIL gaps_read: iaddr=%0d idata=%08h required %08h",
                 i, idata, (i < 3) ? exp_w[i] : EOC);
      end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    load_prog(4, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    ncmp++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || core_rst_n !== 1'b0 ||
        h_ready !== 1'b0 || word_cnt !== (AW+1)'(4)) begin
      nerr++;
      $display("FAIL csum_status: err=%b done=%b crst=%b rdy=%b wc=%0d required 1/0/0/0/4",
               load_err, load_done, core_rst_n, h_ready, word_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      iaddr = AW'(i); #1;
      ncmp++;
      if (idata !== EOC) begin
        nerr++;
        $display("FAIL csum_read: iaddr=%0d idata=%08h required %08h", i, idata, EOC);
      end
    end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens [2];
    lens[0] = 16'h0000;
    lens[1] = 16'h2001;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      send_byte(lens[k][15:8], 1'b0);
      send_byte(lens[k][7:0], 1'b0);
      ncmp++;
      if (load_err !== 1'b1 || h_ready !== 1'b0 || load_done !== 1'b0) begin
        nerr++;
        $display("FAIL bad_len: len=%04h err=%b rdy=%b done=%b required 1/0/0",
                 lens[k], load_err, h_ready, load_done);
      end
    end
  endtask

  task automatic test_full_depth();
    int idx [4];
    do_reset();
    load_prog(1 << AW, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    ncmp++;
    if (load_done !== 1'b1 || core_rst_n !== 1'b1 || word_cnt !== (AW+1)'(1 << AW)) begin
      nerr++;
      $display("FAIL full_status: done=%b crst=%b wc=%0d required 1/1/%0d",
               load_done, core_rst_n, word_cnt, 1 << AW);
    end
    idx[0] = (1 << AW) - 1;
    idx[1] = 0;
    idx[2] = $urandom_range(1, (1 << AW) - 2);
    idx[3] = $urandom_range(1, (1 << AW) - 2);
    foreach (idx[k]) begin
      iaddr = AW'(idx[k]); #1;
      ncmp++;
      if (idata !== exp_w[idx[k]]) begin
        nerr++;
        $display("FAIL full_read: iaddr=%0d idata=%08h required %08h", idx[k], idata, exp_w[idx[k]]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (core_rst_n !== 1'b0 || word_cnt !== '0 || load_done !== 1'b0 ||
        load_err !== 1'b0 || h_ready !== 1'b1) begin
      nerr++;
      $display("FAIL mid_reset: crst=%b wc=%0d done=%b err=%b rdy=%b required 0/0/0/0/1",
               core_rst_n, word_cnt, load_done, load_err, h_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_prog(2, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    ncmp++;
    if (load_done !== 1'b1 || core_rst_n !== 1'b1 || word_cnt !== (AW+1)'(2)) begin
      nerr++;
      $display("FAIL mid_reload: done=%b crst=%b wc=%0d required 1/1/2", load_done, core_rst_n, word_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      iaddr = AW'(i); #1;
      ncmp++;
      if (idata !== ((i < 2) ? exp_w[i] : EOC)) begin
        nerr++;
        $display("FAIL mid_read: iaddr=%0d idata=%08h required %08h",
                 i, idata, (i < 2) ? exp_w[i] : EOC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_csum();
    test_bad_len();
    test_full_depth();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

`default_nettype wire
